// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants and types for the FIFO write-arbitration
// controller (default widths, pointer width, grant indices, priority type).
package fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  // Bit positions of each requester inside the one-hot grant vector.
  localparam int unsigned GNT_REQ0 = 0;
  localparam int unsigned GNT_REQ1 = 1;

  // Which requester wins the next contested cycle.
  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_e;

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grant enable (low blocks every grant)
//   req[1:0]   : requests, bit GNT_REQ0 / GNT_REQ1
//   gnt[1:0]   : one-hot grant, combinational in the request cycle
// Priority toggles only when both requests are granted-contested.
module rr_arb2
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  pri_e pri;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt[GNT_REQ0] = 1'b1;
        2'b10:   gnt[GNT_REQ1] = 1'b1;
        2'b11: begin
          if (pri == PRI_REQ0) gnt[GNT_REQ0] = 1'b1;
          else                 gnt[GNT_REQ1] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= PRI_REQ0;
    end else if (en && (&req)) begin
      pri <= (pri == PRI_REQ0) ? PRI_REQ1 : PRI_REQ0;
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: controller sequencing one fifo_memory (wclk = rclk = clk).
//   req0/wdata0/gnt0, req1/wdata1/gnt1 : two round-robin write requesters
//   rd_req / rd_valid                  : pop request, rdata-valid one cycle later
//   mem_wen/mem_waddr/mem_wdata        : memory write port
//   mem_ren/mem_raddr                  : memory read port
//   full, empty, count                 : occupancy from registered pointers
//   err_ovf, err_udf                   : sticky error flags, built only when
//                                        FIFO_CTRL_ERR_FLAGS_EN is defined
module fifo_wr_arb_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [1:0]    gnt_vec;
  logic          arb_en;

  // Flags come from registered pointers only; no same-cycle bypass.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign count = wptr - rptr;

  // rst_n in the enables forces grants and memory strobes low during reset.
  assign arb_en = ~full & rst_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({req1, req0}),
    .gnt   (gnt_vec)
  );

  assign gnt0      = gnt_vec[GNT_REQ0];
  assign gnt1      = gnt_vec[GNT_REQ1];
  assign mem_wen   = |gnt_vec;
  assign mem_wdata = gnt_vec[GNT_REQ1] ? wdata1 : wdata0;
  assign mem_waddr = wptr[ADDR_WIDTH-1:0];

  assign mem_ren   = rd_req & ~empty & rst_n;
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (mem_wen) wptr <= wptr + PW'(1);
      if (mem_ren) rptr <= rptr + PW'(1);
      rd_valid <= mem_ren;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if ((req0 | req1) & full) ovf_q <= 1'b1;
      if (rd_req & empty)       udf_q <= 1'b1;
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Testbench for fifo_wr_arb_ctrl: directed vectors, a queue-based FIFO model
// checked every cycle, plus hand-computed literal expectations.
module tb_fifo_wr_arb_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rd_valid, mem_wen, mem_ren, full, empty;
  logic          err_ovf, err_udf;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_wr_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .req1      (req1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  always #5 clk = ~clk;

  // Stand-in for fifo_memory (registered read, contents survive reset).
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    if (mem_ren) rdata <= mem[mem_raddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: queue of entries, arithmetic addresses ----------
  logic [DW-1:0] q[$];
  int            pri_m;      // requester that wins the next contest
  int            wcnt, rcnt; // total pushes / pops since reset
  bit            exp_rdv;
  logic [DW-1:0] exp_rdata;
  bit            exp_ovf, exp_udf;
  int            n, g;
  bit            m_full, m_empty, ren;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pri_m = 0; wcnt = 0; rcnt = 0;
      exp_rdv = 0; exp_ovf = 0; exp_udf = 0;
    end else begin
      n       = q.size();
      m_full  = (n == DEPTH);
      m_empty = (n == 0);
      g = -1;
      if (!m_full) begin
        if (req0 && req1) begin g = pri_m; pri_m = 1 - pri_m; end
        else if (req0) g = 0;
        else if (req1) g = 1;
      end
      ren = rd_req && !m_empty;

      chk("m_full",  int'(full),  int'(m_full));
      chk("m_empty", int'(empty), int'(m_empty));
      chk("m_count", int'(count), n);
      chk("m_gnt0",  int'(gnt0),  int'(g == 0));
      chk("m_gnt1",  int'(gnt1),  int'(g == 1));
      chk("m_wen",   int'(mem_wen), int'(g >= 0));
      if (g >= 0) begin
        chk("m_waddr", int'(mem_waddr), wcnt % DEPTH);
        chk("m_wdata", int'(mem_wdata), int'(g == 0 ? wdata0 : wdata1));
      end
      chk("m_ren", int'(mem_ren), int'(ren));
      if (ren) chk("m_raddr", int'(mem_raddr), rcnt % DEPTH);
      chk("m_rd_valid", int'(rd_valid), int'(exp_rdv));
      if (exp_rdv) chk("m_rdata", int'(rdata), int'(exp_rdata));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("m_err_ovf", int'(err_ovf), int'(exp_ovf));
      chk("m_err_udf", int'(err_udf), int'(exp_udf));
`else
      chk("m_err_ovf", int'(err_ovf), 0);
      chk("m_err_udf", int'(err_udf), 0);
`endif
      exp_rdv = ren;
      if (ren) begin exp_rdata = q.pop_front(); rcnt++; end
      if (g >= 0) begin q.push_back(g == 0 ? wdata0 : wdata1); wcnt++; end
      if ((req0 || req1) && m_full) exp_ovf = 1;
      if (rd_req && m_empty)        exp_udf = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r0, input logic [DW-1:0] d0,
                     input bit r1, input logic [DW-1:0] d1, input bit rr);
    @(posedge clk); #1;
    req0 = r0; wdata0 = d0; req1 = r1; wdata1 = d1; rd_req = rr;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req0 = 0; req1 = 0; rd_req = 0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    // 1: single push
    do_reset();
    cyc(1, 4'hA, 0, 0, 0); @(negedge clk);
    chk("t1_gnt0", int'(gnt0), 1);
    chk("t1_wen", int'(mem_wen), 1);
    chk("t1_waddr", int'(mem_waddr), 0);
    chk("t1_wdata", int'(mem_wdata), 10);
    cyc(0, 0, 0, 0, 0); @(negedge clk);
    chk("t1_count", int'(count), 1);
    chk("t1_empty", int'(empty), 0);

    // 2: contested requests alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'h1, 1, 4'h2, 0); @(negedge clk);
      chk("t2_gnt0", int'(gnt0), (i % 2 == 0) ? 1 : 0);
      chk("t2_wdata", int'(mem_wdata), (i % 2 == 0) ? 1 : 2);
      chk("t2_waddr", int'(mem_waddr), i);
    end
    cyc(0, 0, 0, 0, 0); @(negedge clk);
    chk("t2_count", int'(count), 4);

    // 3: fill, then push while full
    for (int i = 0; i < 4; i++) cyc(1, 4'(i + 4), 0, 0, 0);
    cyc(0, 0, 1, 4'h9, 0); @(negedge clk);
    chk("t3_full", int'(full), 1);
    chk("t3_count", int'(count), 8);
    chk("t3_gnt1", int'(gnt1), 0);
    chk("t3_wen", int'(mem_wen), 0);
    cyc(0, 0, 1, 4'h9, 0); @(negedge clk);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("t3_err_ovf", int'(err_ovf), 1);
`else
    chk("t3_err_ovf", int'(err_ovf), 0);
`endif

    // 4: pop after three pushes
    do_reset();
    cyc(1, 4'h3, 0, 0, 0);
    cyc(1, 4'h5, 0, 0, 0);
    cyc(1, 4'h7, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); @(negedge clk);
    chk("t4_ren", int'(mem_ren), 1);
    chk("t4_raddr", int'(mem_raddr), 0);
    cyc(0, 0, 0, 0, 0); @(negedge clk);
    chk("t4_rd_valid", int'(rd_valid), 1);
    chk("t4_rdata", int'(rdata), 3);
    chk("t4_count", int'(count), 2);

    // 5: push + pop while full, then wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 4'(i), 0, 0, 0);
    cyc(1, 4'h9, 0, 0, 1); @(negedge clk);
    chk("t5_gnt0_refused", int'(gnt0), 0);
    chk("t5_ren", int'(mem_ren), 1);
    cyc(1, 4'h9, 0, 0, 0); @(negedge clk);
    chk("t5_count", int'(count), 7);
    chk("t5_gnt0", int'(gnt0), 1);
    chk("t5_waddr_wrap", int'(mem_waddr), 0);
    chk("t5_rdata", int'(rdata), 0);
    cyc(0, 0, 0, 0, 0); @(negedge clk);
    chk("t5_full", int'(full), 1);
    chk("t5_count_full", int'(count), 8);

    // 6: pop while empty, then asynchronous reset mid-fill
    do_reset();
    cyc(0, 0, 0, 0, 1); @(negedge clk);
    chk("t6_ren", int'(mem_ren), 0);
    cyc(0, 0, 0, 0, 0); @(negedge clk);
    chk("t6_rd_valid", int'(rd_valid), 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("t6_err_udf", int'(err_udf), 1);
`else
    chk("t6_err_udf", int'(err_udf), 0);
`endif
    cyc(1, 4'h1, 1, 4'h2, 0);
    cyc(1, 4'h3, 1, 4'h4, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", int'(count), 0);
    chk("t6_async_empty", int'(empty), 1);
    chk("t6_async_gnt0", int'(gnt0), 0);
    chk("t6_async_gnt1", int'(gnt1), 0);
    chk("t6_async_wen", int'(mem_wen), 0);
    req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Single-clock controller that sequences one fifo_memory instance.
- Two write requesters share the memory write port under round-robin arbitration.
- One reader pops entries from the same memory.
- Owns the read/write pointers, full/empty/count flags and the memory enables. Sits between producer logic and fifo_memory, with wclk and rclk both tied to clk.

Parameters:
DATA_WIDTH, 4, width of each FIFO entry
ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH entries (derived localparam, 8 by default)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 push request
wdata0  in  DATA_WIDTH  requester 0 data
gnt0  out  1  requester 0 push accepted this cycle
req1  in  1  requester 1 push request
wdata1  in  DATA_WIDTH  requester 1 data
gnt1  out  1  requester 1 push accepted this cycle
rd_req  in  1  pop request
rd_valid  out  1  memory rdata valid this cycle
mem_wen  out  1  to fifo_memory wen
mem_waddr  out  ADDR_WIDTH  to fifo_memory waddr
mem_wdata  out  DATA_WIDTH  to fifo_memory wdata
mem_ren  out  1  to fifo_memory ren
mem_raddr  out  ADDR_WIDTH  to fifo_memory raddr
full  out  1  FIFO full
empty  out  1  FIFO empty
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
err_ovf  out  1  sticky overflow flag (see Optional Feature)
err_udf  out  1  sticky underflow flag (see Optional Feature)

Behaviour:
- Reset is asynchronous and takes effect immediately:
  - wptr, rptr = 0; count = 0; empty = 1; full = 0; rd_valid = 0.
  - Round-robin priority is set to requester 0.
  - gnt0, gnt1, mem_wen and mem_ren are forced to 0 while rst_n = 0.
  - Memory contents are not cleared; rd_valid gates all reads.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits and wrap naturally, modulo 2*DEPTH.
  - empty = (wptr == rptr).
  - full = MSBs differ and low bits are equal.
  - count = wptr - rptr, computed modulo 2^(ADDR_WIDTH+1).
- Write arbitration (combinational, same cycle):
  - Nothing is granted when full = 1; requesters hold req.
  - If exactly one req is high, that requester is granted.
  - If both are high, the priority holder is granted. Priority then moves to the other requester.
  - Priority changes only on a contested grant.
  - Grants are one-hot.
  - mem_wen = gnt0 | gnt1; mem_wdata = data of the granted requester; mem_waddr = wptr[ADDR_WIDTH-1:0].
  - wptr increments at the clock edge after a grant.
- Read:
  - mem_ren = rd_req & ~empty; mem_raddr = rptr[ADDR_WIDTH-1:0]; rptr increments at the next edge.
  - rd_valid is mem_ren registered: it is high exactly one cycle after the pop, when fifo_memory rdata holds the entry.
- Flags decide acceptance from registered state only:
  - A push and pop in the same cycle while full: pop is accepted, push is refused. The push is granted the next cycle.
  - A push and pop in the same cycle while empty: push is accepted, pop is ignored. There is no bypass path.
  - A push and pop in the same cycle otherwise: both are accepted and count is unchanged.
- A req while full or a rd_req while empty has no effect on pointers.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - err_ovf is set at the clock edge after any cycle with (req0 | req1) & full.
  - err_udf is set at the clock edge after any cycle with rd_req & empty.
  - Both flags are sticky and cleared only by reset.
- Undefined: err_ovf and err_udf are tied to 0 and no flag registers are built.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - pointer-width constant (ADDR_WIDTH+1);
  - grant-index constants (GNT_REQ0, GNT_REQ1).
- Sub-module rr_arb2: two-requester round-robin arbiter with an enable input (~full), a one-hot grant output and an internal priority register. The rest of the block is flat.

Test Plan:
1. Reset, then req0=1 with wdata0=0xA for one cycle -> gnt0=1, mem_wen=1, mem_waddr=0, mem_wdata=0xA; next cycle count=1, empty=0.
2. Reset, then req0 and req1 held for 4 cycles with wdata0=0x1 and wdata1=0x2 -> grants 0,1,0,1; mem_wdata 1,2,1,2; mem_waddr 0..3; count=4.
3. Push 8 entries, then req1 held 2 more cycles -> full=1, count=8, gnt1=0, mem_wen=0; with the macro, err_ovf=1 from the following cycle.
4. After writing 0x3,0x5,0x7, pulse rd_req for one cycle -> mem_ren=1, mem_raddr=0; rd_valid=1 next cycle with memory rdata=0x3; count=2.
5. Full FIFO, req0 and rd_req together -> gnt0=0, mem_ren=1, count=7. Next cycle req0 is granted at mem_waddr=0 (wrap) and full=1 again.
6. Empty FIFO with rd_req=1 -> mem_ren=0 and rd_valid stays 0; with the macro, err_udf=1. Asserting rst_n=0 mid-fill -> count=0, empty=1, gnt0=gnt1=0 immediately, without waiting for a clock edge.
